// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between the FIFO controller and the
// producer/consumer side. The memory data buses are not part of it.
interface fifo_ctrl_if;
  logic       push;
  logic       pop;
  logic       clear;
  logic [3:0] write_addr;
  logic       write_enable;
  logic [3:0] read_addr;
  logic       read_enable;
  logic       read_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  // Producer/consumer side: issues requests, observes pointers and flags.
  modport master (
    output push, pop, clear,
    input  write_addr, write_enable, read_addr, read_enable, read_valid,
    input  full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  // Controller side.
  modport slave (
    input  push, pop, clear,
    output write_addr, write_enable, read_addr, read_enable, read_valid,
    output full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for an 8-entry FIFO memory with a registered
// read port. Wrap-bit pointers give full/empty without a separate counter;
// all flags are decoded from the pointer registers so they never lag them.
module fifo_ctrl #(
  parameter int AFULL_LEVEL  = 6,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic        clk,
  input  logic        rst,
  fifo_ctrl_if.slave  bus
);

  localparam logic [3:0] AFULL_L  = 4'(AFULL_LEVEL);
  localparam logic [3:0] AEMPTY_L = 4'(AEMPTY_LEVEL);

  logic [3:0] wptr;
  logic [3:0] rptr;
  logic       read_valid_q;
  logic       overflow_q;
  logic       underflow_q;

  logic [3:0] occupancy;
  logic       is_full;
  logic       is_empty;
  logic       push_ok;
  logic       pop_ok;
  logic       push_drop;
  logic       pop_drop;

  // Occupancy, full/empty and request acceptance decoded from the pointers.
  // A flush masks both requests and suppresses the error flags.
  always_comb begin
    occupancy = wptr - rptr;
    is_empty  = (wptr == rptr);
    is_full   = (wptr[3] != rptr[3]) && (wptr[2:0] == rptr[2:0]);
    push_ok   = bus.push && !is_full  && !bus.clear;
    pop_ok    = bus.pop  && !is_empty && !bus.clear;
    push_drop = bus.push &&  is_full  && !bus.clear;
    pop_drop  = bus.pop  &&  is_empty && !bus.clear;
  end

  // Pointer advance, read-valid pipeline stage aligned with the memory's
  // registered read, and the sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      read_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else if (bus.clear) begin
      wptr         <= '0;
      rptr         <= '0;
      read_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 4'd1;
      if (pop_ok)  rptr <= rptr + 4'd1;
      read_valid_q <= pop_ok;
      if (push_drop) overflow_q  <= 1'b1;
      if (pop_drop)  underflow_q <= 1'b1;
    end
  end

  assign bus.write_addr   = wptr;
  assign bus.write_enable = push_ok;
  assign bus.read_addr    = rptr;
  assign bus.read_enable  = pop_ok;
  assign bus.read_valid   = read_valid_q;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (occupancy >= AFULL_L);
  assign bus.almost_empty = (occupancy <= AEMPTY_L);
  assign bus.count        = occupancy;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
